// File: rtl/hcsr04_pkg.sv
// Shared types and default timing for the HC-SR04 ping scheduler.
package hcsr04_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_TRIG      = 3'd1,
    S_WAIT_RISE = 3'd2,
    S_MEASURE   = 3'd3,
    S_GUARD     = 3'd4
  } state_t;

  // Defaults assume a 100 MHz clock.
  localparam int DEF_N_SENSORS           = 4;
  localparam int DEF_TRIG_CYCLES         = 1000;
  localparam int DEF_ECHO_TIMEOUT_CYCLES = 3_000_000;
  localparam int DEF_GUARD_CYCLES        = 6_000_000;
  localparam int DEF_COUNT_W             = 22;

  typedef logic [$clog2(DEF_N_SENSORS)-1:0] sensor_id_t;

endpackage

// File: rtl/hcsr04_echo_sync.sv
// One echo pin: 2-FF synchronizer followed by a registered edge detector.
module hcsr04_echo_sync (
  input  logic clock,
  input  logic reset,
  input  logic echo_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= echo_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/hcsr04_ping_scheduler.sv
// Round-robin HC-SR04 ping sequencer: trigger, echo width measurement with
// timeout, and a guard gap between pings.
module hcsr04_ping_scheduler
  import hcsr04_pkg::*;
#(
  parameter int N_SENSORS           = DEF_N_SENSORS,
  parameter int TRIG_CYCLES         = DEF_TRIG_CYCLES,
  parameter int ECHO_TIMEOUT_CYCLES = DEF_ECHO_TIMEOUT_CYCLES,
  parameter int GUARD_CYCLES        = DEF_GUARD_CYCLES,
  parameter int COUNT_W             = DEF_COUNT_W,
  localparam int ID_W = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [N_SENSORS-1:0] sensor_mask,
  input  logic [N_SENSORS-1:0] echo,
  output logic [N_SENSORS-1:0] trig,
  output logic                 busy,
  output logic                 dist_valid,
  output logic [ID_W-1:0]      dist_id,
  output logic [COUNT_W-1:0]   dist_count,
  output logic                 dist_timeout
);

  localparam int T_MAX1 = (TRIG_CYCLES > GUARD_CYCLES) ? TRIG_CYCLES : GUARD_CYCLES;
  localparam int T_MAX  = (T_MAX1 > ECHO_TIMEOUT_CYCLES) ? T_MAX1 : ECHO_TIMEOUT_CYCLES;
  localparam int TMR_W  = $clog2(T_MAX + 1);

  logic [N_SENSORS-1:0] lvl, rise, fall;

  for (genvar g = 0; g < N_SENSORS; g++) begin : g_sync
    hcsr04_echo_sync u_sync (
      .clock   (clock),
      .reset   (reset),
      .echo_in (echo[g]),
      .level   (lvl[g]),
      .rise    (rise[g]),
      .fall    (fall[g])
    );
  end

  // First set mask bit strictly after last, wrapping; last itself has lowest priority.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_SENSORS-1:0] m,
                                              input logic [ID_W-1:0]      last);
    logic [ID_W-1:0] p, c;
    p = last;
    for (int i = N_SENSORS; i >= 1; i--) begin
      c = ID_W'((int'(last) + i) % N_SENSORS);
      if (m[c]) p = c;
    end
    return p;
  endfunction

  state_t               state;
  logic [ID_W-1:0]      sel, last_id, pick;
  logic [TMR_W-1:0]     timer;
  logic [COUNT_W-1:0]   count, count_inc;
  logic [N_SENSORS-1:0] pick_oh;
  logic                 sel_rise, sel_fall, expired;

  assign pick      = rr_pick(sensor_mask, last_id);
  assign sel_rise  = rise[sel];
  assign sel_fall  = fall[sel];
  assign expired   = (timer == TMR_W'(ECHO_TIMEOUT_CYCLES - 1));
  assign count_inc = (&count) ? count : count + COUNT_W'(1);

  always_comb begin
    pick_oh       = '0;
    pick_oh[pick] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      trig         <= '0;
      busy         <= 1'b0;
      dist_valid   <= 1'b0;
      dist_id      <= '0;
      dist_count   <= '0;
      dist_timeout <= 1'b0;
      last_id      <= ID_W'(N_SENSORS - 1);
      sel          <= '0;
      timer        <= '0;
      count        <= '0;
    end else begin
      dist_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (enable && |sensor_mask) begin
            sel   <= pick;
            trig  <= pick_oh;
            busy  <= 1'b1;
            timer <= '0;
            state <= S_TRIG;
          end
        end
        S_TRIG: begin
          if (timer == TMR_W'(TRIG_CYCLES - 1)) begin
            trig  <= '0;
            timer <= '0;
            count <= '0;
            state <= S_WAIT_RISE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_WAIT_RISE: begin
          if (expired) begin
            dist_valid   <= 1'b1;
            dist_id      <= sel;
            dist_count   <= COUNT_W'(sel_rise);
            dist_timeout <= 1'b1;
            last_id      <= sel;
            timer        <= '0;
            state        <= S_GUARD;
          end else begin
            timer <= timer + TMR_W'(1);
            if (sel_rise) begin
              count <= COUNT_W'(1);
              state <= S_MEASURE;
            end
          end
        end
        S_MEASURE: begin
          // Synced echo is high on every non-fall cycle here, so count_inc is the running width.
          if (sel_fall || expired) begin
            dist_valid   <= 1'b1;
            dist_id      <= sel;
            dist_count   <= sel_fall ? count : count_inc;
            dist_timeout <= ~sel_fall;
            last_id      <= sel;
            timer        <= '0;
            state        <= S_GUARD;
          end else begin
            count <= count_inc;
            timer <= timer + TMR_W'(1);
          end
        end
        S_GUARD: begin
          if (timer == TMR_W'(GUARD_CYCLES - 1)) begin
            timer <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          trig  <= '0;
          busy  <= 1'b0;
          timer <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hcsr04_ping_scheduler.sv
// Directed-plus-random bench for the ping scheduler, with a 6-bit-count twin for saturation.
module tb_hcsr04_ping_scheduler;

  localparam int N = 4, TRIG = 10, TO = 200, GUARD = 50, CW = 8, CW6 = 6;

  logic clock = 1'b0;
  logic reset = 1'b1, enable = 1'b0;
  logic [N-1:0] sensor_mask = '0, echo = '0;
  logic [N-1:0] trig, trig6;
  logic busy, busy6, dv, dv6, to, to6;
  logic [1:0] id, id6;
  logic [CW-1:0] cnt;
  logic [CW6-1:0] cnt6;

  always #5 clock = ~clock;

  hcsr04_ping_scheduler #(.N_SENSORS(N), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT_CYCLES(TO),
                          .GUARD_CYCLES(GUARD), .COUNT_W(CW)) dut (
    .clock(clock), .reset(reset), .enable(enable), .sensor_mask(sensor_mask), .echo(echo),
    .trig(trig), .busy(busy), .dist_valid(dv), .dist_id(id), .dist_count(cnt), .dist_timeout(to));

  hcsr04_ping_scheduler #(.N_SENSORS(N), .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT_CYCLES(TO),
                          .GUARD_CYCLES(GUARD), .COUNT_W(CW6)) dut6 (
    .clock(clock), .reset(reset), .enable(enable), .sensor_mask(sensor_mask), .echo(echo),
    .trig(trig6), .busy(busy6), .dist_valid(dv6), .dist_id(id6), .dist_count(cnt6), .dist_timeout(to6));

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct { int c; int id; int cnt; int to; int cnt6; } res_t;
  res_t resq[$];
  int onehot_bad = 0, dv_double = 0, pair_bad = 0;
  logic dv_q = 1'b0;

  always @(negedge clock) begin
    if ($countones(trig) > 1) onehot_bad++;
    if (dv && dv_q) dv_double++;
    dv_q = dv;
    if (trig !== trig6 || dv !== dv6 || busy !== busy6) pair_bad++;
    if (dv) resq.push_back('{cyc, int'(id), int'(cnt), int'(to), int'(cnt6)});
  end

  int checks = 0, passed = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_near(input string tag, input int obs, input int exp);
    checks++;
    assert (obs >= exp - 1 && obs <= exp + 1) passed++;
    else $error("FAIL %s: observed %0d expected %0d+-1", tag, obs, exp);
  endtask

  logic [N-1:0] own = '0;
  bit noise = 1'b0;

  // Unselected channels see random chatter that must never be observed.
  task automatic tick();
    @(posedge clock);
    #1;
    if (noise) echo = (echo & own) | (N'($urandom) & ~own);
  endtask

  int last_id = N - 1;

  function automatic int next_pick(input logic [N-1:0] m, input int last);
    for (int i = 1; i <= N; i++) if (m[(last + i) % N]) return (last + i) % N;
    return -1;
  endfunction

  // Cycle t counts from the trig falling edge; the pin reaches the FSM 2 cycles late.
  task automatic model(input int s, input int k, output int e_to, output int e_cnt, output int e_off);
    int r, f;
    r = s + 2;
    f = s + k + 2;
    if (k == 0 || r > TO - 1) begin e_to = 1; e_cnt = 0;     e_off = TO;    end
    else if (f <= TO - 1)     begin e_to = 0; e_cnt = k;     e_off = f + 1; end
    else                      begin e_to = 1; e_cnt = TO - r; e_off = TO;   end
  endtask

  task automatic ping(input int s, input int k, input bit drop_en, input int prev, output int strobe_c);
    int exp_id, got, rise_c, fall_c, j, e_to, e_cnt, e_off, e6;
    res_t r;
    exp_id = next_pick(sensor_mask, last_id);
    got = -1; rise_c = 0; strobe_c = -1;
    for (int i = 0; i < 400 && got < 0; i++) begin
      tick();
      for (int b = 0; b < N; b++) if (trig[b]) begin got = b; rise_c = cyc; end
    end
    chk("trig_id", got, exp_id);
    if (got < 0) return;
    if (prev >= 0) chk("b2b_gap", rise_c - prev, GUARD + 1);
    own = '0; own[got] = 1'b1; echo[got] = 1'b0;
    fall_c = -1;
    for (int i = 0; i < 100 && fall_c < 0; i++) begin
      tick();
      if (trig == '0) fall_c = cyc;
    end
    chk("trig_width", fall_c - rise_c, TRIG);
    repeat (s) tick();
    model(s, k, e_to, e_cnt, e_off);
    if (k > 0) echo[got] = 1'b1;
    j = 0;
    while ((strobe_c < 0 || j < k) && j < 700) begin
      tick();
      j++;
      if (j == k) echo[got] = 1'b0;
      if (drop_en && j == 3) enable = 1'b0;
      if (strobe_c < 0 && resq.size() > 0) begin r = resq.pop_front(); strobe_c = r.c; end
    end
    last_id = exp_id;
    if (strobe_c < 0) begin chk("strobe_seen", 0, 1); return; end
    chk("res_id", r.id, exp_id);
    chk("res_timeout", r.to, e_to);
    chk_near("res_count", r.cnt, e_cnt);
    if (e_to) chk("strobe_time", strobe_c - fall_c, e_off);
    else      chk_near("strobe_time", strobe_c - fall_c, e_off);
    e6 = (e_cnt > 63) ? 63 : e_cnt;
    if (e_cnt >= 65) chk("res_count6", r.cnt6, 63);
    else             chk_near("res_count6", r.cnt6, e6);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int sc, ps, k, got, bad;
    repeat (3) tick();
    chk("rst_trig", int'(trig), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(dv), 0);
    chk("rst_id", int'(id), 0);
    chk("rst_count", int'(cnt), 0);
    chk("rst_timeout", int'(to), 0);
    reset = 1'b0;

    // Round robin over 1011 from reset: 0,1,3,0
    sensor_mask = 4'b1011; enable = 1'b1; noise = 1'b1; ps = -1;
    for (int p = 0; p < 4; p++) begin
      ping($urandom_range(0, 20), 30, 1'b0, ps, sc);
      ps = sc;
    end

    // Reset in the middle of the next trigger pulse
    got = -1;
    for (int i = 0; i < 200 && got < 0; i++) begin
      tick();
      for (int b = 0; b < N; b++) if (trig[b]) got = b;
    end
    chk("pre_reset_id", got, next_pick(sensor_mask, last_id));
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_trig", int'(trig), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_valid", int'(dv), 0);
    chk("mid_rst_id", int'(id), 0);
    chk("mid_rst_count", int'(cnt), 0);
    chk("mid_rst_timeout", int'(to), 0);
    chk("mid_rst_nostrobe", resq.size(), 0);
    last_id = N - 1;
    ping(5, 25, 1'b0, -1, sc);

    // Single echo, enable dropped during MEASURE
    sensor_mask = 4'b0001;
    ping(20, 40, 1'b1, sc, sc);
    while (cyc < sc + GUARD - 1) tick();
    chk("guard_busy", int'(busy), 1);
    tick();
    chk("idle_busy", int'(busy), 0);
    bad = 0;
    repeat (100) begin tick(); if (trig != '0) bad++; end
    chk("no_trig_disabled", bad, 0);

    // No echo, then long echo saturating the 6-bit twin
    sensor_mask = 4'b0100; enable = 1'b1;
    ping(0, 0, 1'b0, -1, sc);
    sensor_mask = 4'b0010;
    ping(0, 300, 1'b1, sc, sc);
    for (int i = 0; i < 200 && busy; i++) tick();
    chk("long_idle_busy", int'(busy), 0);

    // Random masks and pulses, masks changed during GUARD
    enable = 1'b1; ps = -1;
    for (int p = 0; p < 8; p++) begin
      sensor_mask = N'($urandom_range(1, 15));
      k = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 150);
      ping($urandom_range(0, 30), k, 1'b0, ps, sc);
      ps = sc;
    end
    enable = 1'b0;
    repeat (120) tick();

    chk("trig_onehot", onehot_bad, 0);
    chk("strobe_1cycle", dv_double, 0);
    chk("twin_agree", pair_bad, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
